fwd_hazard_unit: RTL

Parametrised successor to the ID-stage forwarding logic. It serves NUM_SRC register read ports from four sources in priority order: EXE, MEM, WB, then register file. Loads stall the front end only on a real load-use dependency, not on every load. A registered FSM tracks load-use bubbles and multi-cycle data-memory waits, with a stall-cycle counter and a sticky memory-timeout flag. It sits between the ID stage and the EXE/MEM/WB pipeline registers.

---
 rtl/fwd_hazard_unit_if.sv | 57 +++++
 rtl/fwd_hazard_unit.sv | 101 ++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - ID/EXE/MEM/WB operand and stall bus for fwd_hazard_unit
interface fwd_hazard_unit_if #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 16
);
  logic                      id_valid;
  logic [NUM_SRC-1:0]        id_src_read;
  logic [NUM_SRC*ADDR_W-1:0] id_src_addr;
  logic [NUM_SRC*DATA_W-1:0] id_src_rf;
  logic [ADDR_W-1:0]         exe_write_addr;
  logic                      exe_reg_write;
  logic                      exe_is_load;
  logic                      exe_movsrc;
  logic [DATA_W-1:0]         exe_alu_data;
  logic [DATA_W-1:0]         exe_mov_data;
  logic [ADDR_W-1:0]         mem_write_addr;
  logic                      mem_reg_write;
  logic                      mem_DM_read;
  logic                      mem_movsrc;
  logic [DATA_W-1:0]         mem_alu_data;
  logic [DATA_W-1:0]         mem_mov_data;
  logic [DATA_W-1:0]         mem_data;
  logic                      mem_data_valid;
  logic [ADDR_W-1:0]         wb_write_addr;
  logic                      wb_reg_write;
  logic [DATA_W-1:0]         wb_data;
  logic                      perf_clr;
  logic [NUM_SRC*DATA_W-1:0] forward_data;
  logic                      stall_pc;
  logic                      stall_if_id;
  logic                      flush_id_exe;
  logic                      stall_id_exe;
  logic                      stall_exe_mem;
  logic [1:0]                state;
  logic [CNT_W-1:0]          stall_cnt;
  logic                      err_timeout;

  modport master (
    output id_valid, id_src_read, id_src_addr, id_src_rf,
    output exe_write_addr, exe_reg_write, exe_is_load, exe_movsrc, exe_alu_data, exe_mov_data,
    output mem_write_addr, mem_reg_write, mem_DM_read, mem_movsrc, mem_alu_data, mem_mov_data,
    output mem_data, mem_data_valid, wb_write_addr, wb_reg_write, wb_data, perf_clr,
    input  forward_data, stall_pc, stall_if_id, flush_id_exe, stall_id_exe, stall_exe_mem,
    input  state, stall_cnt, err_timeout
  );

  modport slave (
    input  id_valid, id_src_read, id_src_addr, id_src_rf,
    input  exe_write_addr, exe_reg_write, exe_is_load, exe_movsrc, exe_alu_data, exe_mov_data,
    input  mem_write_addr, mem_reg_write, mem_DM_read, mem_movsrc, mem_alu_data, mem_mov_data,
    input  mem_data, mem_data_valid, wb_write_addr, wb_reg_write, wb_data, perf_clr,
    output forward_data, stall_pc, stall_if_id, flush_id_exe, stall_id_exe, stall_exe_mem,
    output state, stall_cnt, err_timeout
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - ID operand forwarding with load-use and MEM-wait hazard control
module fwd_hazard_unit #(
  parameter int NUM_SRC  = 3,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input logic              clk,
  input logic              rst,
  fwd_hazard_unit_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic [1:0] {RUN = 2'd0, LU = 2'd1, WAIT = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              err_timeout_q, err_timeout_d;
  logic              load_use, mem_wait;
  logic [DATA_W-1:0] exe_res, mem_res;
  logic [ADDR_W-1:0] src_addr;
  logic [NUM_SRC*DATA_W-1:0] fwd;

  always_comb begin
    exe_res  = bus.exe_movsrc ? bus.exe_mov_data : bus.exe_alu_data;
    mem_res  = bus.mem_DM_read ? bus.mem_data
             : (bus.mem_movsrc ? bus.mem_mov_data : bus.mem_alu_data);
    fwd      = bus.id_src_rf;
    load_use = 1'b0;
    src_addr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_addr = bus.id_src_addr[i*ADDR_W +: ADDR_W];
      if (bus.id_src_read[i]) begin
        if (bus.exe_reg_write && src_addr == bus.exe_write_addr)
          fwd[i*DATA_W +: DATA_W] = exe_res;
        else if (bus.mem_reg_write && src_addr == bus.mem_write_addr)
          fwd[i*DATA_W +: DATA_W] = mem_res;
        else if (bus.wb_reg_write && src_addr == bus.wb_write_addr)
          fwd[i*DATA_W +: DATA_W] = bus.wb_data;
        if (src_addr == bus.exe_write_addr)
          load_use = 1'b1;
      end
    end
    load_use = load_use && bus.id_valid && bus.exe_reg_write && bus.exe_is_load;
    mem_wait = bus.mem_reg_write && bus.mem_DM_read && !bus.mem_data_valid;
  end

  // A MEM wait freezes the whole front of the pipe; a load-use only bubbles ID/EXE.
  assign bus.forward_data  = fwd;
  assign bus.stall_pc      = mem_wait || load_use;
  assign bus.stall_if_id   = mem_wait || load_use;
  assign bus.flush_id_exe  = !mem_wait && load_use;
  assign bus.stall_id_exe  = mem_wait;
  assign bus.stall_exe_mem = mem_wait;
  assign bus.state         = state_q;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.err_timeout   = err_timeout_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     state_d = mem_wait ? WAIT : (load_use ? LU : RUN);
      LU:      state_d = mem_wait ? WAIT : (load_use ? LU : RUN);
      WAIT:    state_d = mem_wait ? WAIT : (load_use ? LU : RUN);
      default: state_d = RUN;
    endcase

    wait_cnt_d = '0;
    if (mem_wait)
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;

    stall_cnt_d   = stall_cnt_q;
    err_timeout_d = err_timeout_q;
    if (bus.perf_clr) begin
      stall_cnt_d   = '0;
      err_timeout_d = 1'b0;
    end else begin
      if (bus.stall_pc && stall_cnt_q != '1)
        stall_cnt_d = stall_cnt_q + 1'b1;
      if (wait_cnt_d == WAIT_MAX && wait_cnt_q != WAIT_MAX)
        err_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end
endmodule
